// File: rtl/axis_pbs_bridge.sv
// ---------------------------------------------------------------------------
// axis_pbs_bridge
//
// Purpose:
//   Bidirectional bridge between 64-bit AXI4-Stream packets and the 64-bit
//   PBS packet bus (data, ctrl, wr, rdy) used by legacy pipeline modules.
//   - AXIS->PBS: prepends a module-header word (TUSER[63:0], ctrl 0xFF).
//     This path is purely combinational (zero latency).
//   - PBS->AXIS: strips the module-header word into TUSER[63:0] and queues
//     the payload words in a 4-entry FIFO.
//   The two directions are independent and share one clock.
//
// PBS ctrl encoding: 0xFF = module header, 0x00 = mid-packet word,
//   EOP word = one-hot at the highest valid byte (byte k = bits 8k+7:8k).
//
// Handshakes:
//   AXIS: a beat transfers on a rising edge where TVALID & TREADY are both 1.
//   PBS:  a word transfers on a rising edge where WR is 1; a writer asserts
//         WR only while the receiver's RDY is 1 (S_PBS_RDY is registered and
//         leaves room for one extra word written the cycle after it falls).
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   S_AXIS_T*                    AXIS packet input (to PBS)
//   M_PBS_DATA/CTRL/WR, M_PBS_RDY PBS output and its downstream ready
//   S_PBS_DATA/CTRL/WR, S_PBS_RDY PBS input and the bridge's ready
//   M_AXIS_T*                    AXIS packet output (from PBS)
//   STAT_*                       packet/drop counters (optional)
//   DBG_A2P_STATE, DBG_P2A_STATE current FSM states (0 = HDR / EXP_HDR)
//
// Optional feature macro: AXIS_PBS_BRIDGE_STATS_EN
//   When defined, adds STAT_A2P_PKTS, STAT_P2A_PKTS and STAT_P2A_DROPS
//   (32-bit, cleared on reset, wrapping). Datapath behaviour is unchanged.
// ---------------------------------------------------------------------------
module axis_pbs_bridge #(
    parameter int C_S_AXIS_TDATA_WIDTH = 64,
    parameter int C_M_AXIS_TDATA_WIDTH = 64,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_PBS_DATA_WIDTH   = 64,
    parameter int C_M_PBS_DATA_WIDTH   = 64
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    // AXIS slave (towards PBS)
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    // PBS master
    output logic [C_M_PBS_DATA_WIDTH-1:0]     M_PBS_DATA,
    output logic [C_M_PBS_DATA_WIDTH/8-1:0]   M_PBS_CTRL,
    output logic                              M_PBS_WR,
    input  logic                              M_PBS_RDY,
    // PBS slave
    input  logic [C_S_PBS_DATA_WIDTH-1:0]     S_PBS_DATA,
    input  logic [C_S_PBS_DATA_WIDTH/8-1:0]   S_PBS_CTRL,
    input  logic                              S_PBS_WR,
    output logic                              S_PBS_RDY,
    // AXIS master (from PBS)
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
`ifdef AXIS_PBS_BRIDGE_STATS_EN
    output logic [31:0]                       STAT_A2P_PKTS,
    output logic [31:0]                       STAT_P2A_PKTS,
    output logic [31:0]                       STAT_P2A_DROPS,
`endif
    output logic                              DBG_A2P_STATE,
    output logic                              DBG_P2A_STATE
);

    typedef enum logic {A2P_HDR = 1'b0, A2P_PAY = 1'b1} a2p_state_t;
    typedef enum logic {P2A_EXP_HDR = 1'b0, P2A_IN_PKT = 1'b1} p2a_state_t;

    // -----------------------------------------------------------------------
    // AXIS -> PBS
    // -----------------------------------------------------------------------
    a2p_state_t r_a2p_state;
    a2p_state_t w_a2p_next;
    logic [7:0] w_eop_ctrl;
    logic       w_a2p_tready;
    logic       w_pbs_wr;
    logic [63:0] w_pbs_data;
    logic [7:0]  w_pbs_ctrl;

    // Upper TUSER half carries nothing the PBS header needs.
    logic w_unused_tuser;
    assign w_unused_tuser = ^S_AXIS_TUSER[C_S_AXIS_TUSER_WIDTH-1:64];

    // One-hot of the highest set TSTRB bit; an all-zero strobe maps to byte 0.
    always_comb begin
        w_eop_ctrl = 8'h01;
        for (int i = 0; i < 8; i++) begin
            if (S_AXIS_TSTRB[i]) w_eop_ctrl = 8'h01 << i;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_a2p_state <= A2P_HDR;
        else        r_a2p_state <= w_a2p_next;
    end

    always_comb begin
        w_a2p_next   = r_a2p_state;
        w_a2p_tready = 1'b0;
        w_pbs_wr     = 1'b0;
        w_pbs_data   = '0;
        w_pbs_ctrl   = '0;
        if (!ARESET) begin
            w_pbs_wr = S_AXIS_TVALID & M_PBS_RDY;
            case (r_a2p_state)
                A2P_HDR: begin
                    // Header is emitted while the first beat waits (TREADY=0).
                    w_pbs_data = S_AXIS_TUSER[63:0];
                    w_pbs_ctrl = 8'hFF;
                    if (w_pbs_wr) w_a2p_next = A2P_PAY;
                end
                A2P_PAY: begin
                    w_a2p_tready = M_PBS_RDY;
                    w_pbs_data   = S_AXIS_TDATA;
                    w_pbs_ctrl   = S_AXIS_TLAST ? w_eop_ctrl : 8'h00;
                    if (w_pbs_wr && S_AXIS_TLAST) w_a2p_next = A2P_HDR;
                end
                default: w_a2p_next = A2P_HDR;
            endcase
        end
    end

    assign S_AXIS_TREADY = w_a2p_tready;
    assign M_PBS_WR      = w_pbs_wr;
    assign M_PBS_DATA    = w_pbs_data;
    assign M_PBS_CTRL    = w_pbs_ctrl;
    assign DBG_A2P_STATE = r_a2p_state;

    // -----------------------------------------------------------------------
    // PBS -> AXIS
    // -----------------------------------------------------------------------
    p2a_state_t r_p2a_state;
    p2a_state_t w_p2a_next;
    logic       w_push;
    logic       w_latch_hdr;
    logic       w_drop;
    logic       w_do_push;
    logic       w_pop;

    logic [63:0] r_hdr;
    logic [63:0] r_mem_hdr  [4];
    logic [63:0] r_mem_data [4];
    logic [7:0]  r_mem_ctrl [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [2:0]  w_count_next;
    logic        r_pbs_rdy;

    logic [63:0] w_head_hdr;
    logic [63:0] w_head_data;
    logic [7:0]  w_head_ctrl;
    logic [7:0]  w_head_mask;
    logic        w_valid;
    logic        w_last;

    always_ff @(posedge ACLK) begin
        if (ARESET) r_p2a_state <= P2A_EXP_HDR;
        else        r_p2a_state <= w_p2a_next;
    end

    always_comb begin
        w_p2a_next  = r_p2a_state;
        w_push      = 1'b0;
        w_latch_hdr = 1'b0;
        w_drop      = 1'b0;
        if (S_PBS_WR) begin
            case (r_p2a_state)
                P2A_EXP_HDR: begin
                    if (S_PBS_CTRL == 8'hFF) begin
                        w_latch_hdr = 1'b1;
                        w_p2a_next  = P2A_IN_PKT;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                P2A_IN_PKT: begin
                    w_push = 1'b1;
                    if (S_PBS_CTRL != 8'h00) w_p2a_next = P2A_EXP_HDR;
                end
                default: w_p2a_next = P2A_EXP_HDR;
            endcase
        end
    end

    assign w_valid     = !ARESET && (r_count != 3'd0);
    assign w_pop       = w_valid & M_AXIS_TREADY;
    // A full FIFO can still take a word when its head leaves the same cycle.
    assign w_do_push   = w_push & ((r_count != 3'd4) | w_pop);
    assign w_count_next = r_count + {2'b00, w_do_push} - {2'b00, w_pop};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_hdr     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pbs_rdy <= 1'b0;
        end else begin
            if (w_latch_hdr) r_hdr <= S_PBS_DATA;
            if (w_do_push)   r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count   <= w_count_next;
            // Based on the next occupancy so a late word still finds a slot.
            r_pbs_rdy <= (w_count_next <= 3'd2);
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_do_push && !ARESET) begin
            r_mem_hdr[r_wr_ptr]  <= r_hdr;
            r_mem_data[r_wr_ptr] <= S_PBS_DATA;
            r_mem_ctrl[r_wr_ptr] <= S_PBS_CTRL;
        end
    end

    assign w_head_hdr  = r_mem_hdr[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_head_ctrl = r_mem_ctrl[r_rd_ptr];
    assign w_last      = w_valid && (w_head_ctrl != 8'h00);

    // Bytes 0..h valid, where h is the highest set ctrl bit.
    always_comb begin
        w_head_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (w_head_ctrl[i]) w_head_mask = 8'hFF >> (7 - i);
        end
    end

    assign S_PBS_RDY     = r_pbs_rdy;
    assign M_AXIS_TVALID = w_valid;
    assign M_AXIS_TLAST  = w_last;
    assign M_AXIS_TDATA  = w_valid ? w_head_data : '0;
    assign M_AXIS_TSTRB  = !w_valid ? 8'h00 : (w_last ? w_head_mask : 8'hFF);
    assign M_AXIS_TUSER  = w_valid ? {{(C_M_AXIS_TUSER_WIDTH-64){1'b0}}, w_head_hdr} : '0;
    assign DBG_P2A_STATE = r_p2a_state;

`ifdef AXIS_PBS_BRIDGE_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
    logic [31:0] r_stat_a2p_pkts;
    logic [31:0] r_stat_p2a_pkts;
    logic [31:0] r_stat_p2a_drops;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_stat_a2p_pkts  <= '0;
            r_stat_p2a_pkts  <= '0;
            r_stat_p2a_drops <= '0;
        end else begin
            if (w_pbs_wr && (r_a2p_state == A2P_PAY) && S_AXIS_TLAST)
                r_stat_a2p_pkts <= r_stat_a2p_pkts + 32'd1;
            if (w_pop && w_last)
                r_stat_p2a_pkts <= r_stat_p2a_pkts + 32'd1;
            if (w_drop)
                r_stat_p2a_drops <= r_stat_p2a_drops + 32'd1;
        end
    end

    assign STAT_A2P_PKTS  = r_stat_a2p_pkts;
    assign STAT_P2A_PKTS  = r_stat_p2a_pkts;
    assign STAT_P2A_DROPS = r_stat_p2a_drops;
`endif

endmodule

// File: tb/tb_axis_pbs_bridge.sv
// ---------------------------------------------------------------------------
// tb_axis_pbs_bridge
//
// Self-checking bench for axis_pbs_bridge. Expected PBS words and AXIS beats
// are queued when stimulus is driven and compared when the DUT emits them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_pbs_bridge;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [63:0]  S_AXIS_TDATA;
    logic [7:0]   S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic [63:0]  M_PBS_DATA;
    logic [7:0]   M_PBS_CTRL;
    logic         M_PBS_WR;
    logic         M_PBS_RDY;
    logic [63:0]  S_PBS_DATA;
    logic [7:0]   S_PBS_CTRL;
    logic         S_PBS_WR;
    logic         S_PBS_RDY;
    logic [63:0]  M_AXIS_TDATA;
    logic [7:0]   M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic         DBG_A2P_STATE;
    logic         DBG_P2A_STATE;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 0;      // 0: M_PBS_RDY high, 1: toggling, 2: low
    int trdy_mode = 0;     // 0: M_AXIS_TREADY high, 2: low
    int pbs_wr_cnt = 0;

    logic [71:0]  a2p_q[$];   // {data, ctrl}
    logic [200:0] p2a_q[$];   // {tdata, tstrb, tlast, tuser}
    logic         tb_in_pkt;
    logic [63:0]  tb_hdr;

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    axis_pbs_bridge dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
        .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_PBS_DATA(M_PBS_DATA), .M_PBS_CTRL(M_PBS_CTRL),
        .M_PBS_WR(M_PBS_WR), .M_PBS_RDY(M_PBS_RDY),
        .S_PBS_DATA(S_PBS_DATA), .S_PBS_CTRL(S_PBS_CTRL),
        .S_PBS_WR(S_PBS_WR), .S_PBS_RDY(S_PBS_RDY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .DBG_A2P_STATE(DBG_A2P_STATE), .DBG_P2A_STATE(DBG_P2A_STATE)
    );

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] exp_a2p_ctrl(input logic [7:0] strb);
        logic [7:0] r;
        logic       found;
        r = 8'h01;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (strb[i] && !found) begin
                r = 8'h00;
                r[i] = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_tstrb(input logic [7:0] ctrl);
        logic [7:0] m;
        logic       found;
        m = 8'h00;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (ctrl[i]) found = 1'b1;
            m[i] = found;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- downstream ready generators ----------------
    initial begin
        M_PBS_RDY = 1'b1;
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            case (rdy_mode)
                0:       M_PBS_RDY = 1'b1;
                1:       M_PBS_RDY = ~M_PBS_RDY;
                default: M_PBS_RDY = 1'b0;
            endcase
            M_AXIS_TREADY = (trdy_mode == 0);
        end
    end

    // ---------------- scoreboard monitors ----------------
    always @(negedge ACLK) begin
        if (M_PBS_WR) begin
            check("a2p_word_expected", a2p_q.size() != 0, 1);
            if (a2p_q.size() != 0) check("a2p_word", {M_PBS_DATA, M_PBS_CTRL}, a2p_q.pop_front());
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            check("p2a_beat_expected", p2a_q.size() != 0, 1);
            if (p2a_q.size() != 0)
                check("p2a_beat", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER},
                      p2a_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axis_beat(input logic [63:0] d, input logic [7:0] s, input logic l,
                             input logic [63:0] u, input bit first);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        if (first) a2p_q.push_back({u, 8'hFF});
        a2p_q.push_back({d, l ? exp_a2p_ctrl(s) : 8'h00});
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TSTRB  = s;
        S_AXIS_TLAST  = l;
        S_AXIS_TUSER  = {$urandom(), $urandom(), u};
        while (!done && n < 500) begin
            @(negedge ACLK);
            if (!first) check("tready_mirror", S_AXIS_TREADY, M_PBS_RDY);
            done = S_AXIS_TREADY;
            @(posedge ACLK); #1;
            n++;
        end
        check("axis_accept_wait", done, 1);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic axis_rand_pkt(input int beats, input logic [7:0] last_strb, input logic [63:0] u);
        for (int i = 0; i < beats; i++)
            axis_beat({$urandom(), $urandom()}, (i == beats - 1) ? last_strb : 8'hFF,
                      i == beats - 1, u, i == 0);
    endtask

    task automatic pbs_word(input logic [63:0] d, input logic [7:0] c);
        int n;
        n = 0;
        while (!S_PBS_RDY && n < 500) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("pbs_rdy_wait", n < 500, 1);
        if (!tb_in_pkt) begin
            if (c == 8'hFF) begin
                tb_hdr = d;
                tb_in_pkt = 1'b1;
            end
        end else begin
            p2a_q.push_back({d, (c == 8'h00) ? 8'hFF : exp_tstrb(c), c != 8'h00, {64'h0, tb_hdr}});
            if (c != 8'h00) tb_in_pkt = 1'b0;
        end
        S_PBS_WR   = 1'b1;
        S_PBS_DATA = d;
        S_PBS_CTRL = c;
        @(posedge ACLK); #1;
        pbs_wr_cnt++;
        S_PBS_WR   = 1'b0;
        S_PBS_DATA = '0;
        S_PBS_CTRL = '0;
    endtask

    task automatic pbs_rand_pkt(input logic [63:0] h, input int words, input logic [7:0] eop);
        pbs_word(h, 8'hFF);
        for (int i = 0; i < words; i++)
            pbs_word({$urandom(), $urandom()}, (i == words - 1) ? eop : 8'h00);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((a2p_q.size() != 0 || p2a_q.size() != 0) && n < 1000) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("drain_wait", n < 1000, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_pbs_wr"}, M_PBS_WR, 0);
        check({tag, "_s_axis_tready"}, S_AXIS_TREADY, 0);
        check({tag, "_m_pbs_data_ctrl"}, {M_PBS_DATA, M_PBS_CTRL}, 0);
        check({tag, "_s_pbs_rdy"}, S_PBS_RDY, 0);
        check({tag, "_m_axis_tvalid"}, M_AXIS_TVALID, 0);
        check({tag, "_m_axis_outs"}, {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ARESET = 1'b1;
        S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
        S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
        S_PBS_DATA = '0; S_PBS_CTRL = '0; S_PBS_WR = 1'b0;
        tb_in_pkt = 1'b0;
        tb_hdr = '0;

        // Power-on reset, with a valid AXIS beat waiting that must not leak.
        repeat (3) @(posedge ACLK);
        #1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TUSER = {64'h0, 64'h1234_5678_9ABC_DEF0};
        @(negedge ACLK);
        check_reset_outputs("por");
        @(posedge ACLK); #1;
        S_AXIS_TVALID = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rdy_first_cycle", S_PBS_RDY, 0);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("rdy_second_cycle", S_PBS_RDY, 1);
        @(posedge ACLK); #1;

        // AXIS -> PBS reference packet.
        axis_beat(64'hEFBEFECAFECAFECA, 8'hFF, 1'b0, 64'hCAFEBEEFDEADCAFE, 1'b1);
        axis_beat(64'h00000008EFBEEFBE, 8'hFF, 1'b0, 64'hCAFEBEEFDEADCAFE, 1'b0);
        for (int n = 0; n <= 13; n++)
            axis_beat({8{8'(n)}}, 8'hFF, n == 13, 64'hCAFEBEEFDEADCAFE, 1'b0);
        wait_idle();

        // PBS -> AXIS reference packet.
        pbs_word(64'hCAFEBEEFDEADCAFE, 8'hFF);
        pbs_word(64'h0000_0A0B_0C0D_0E0F, 8'h00);
        pbs_word(64'h0000_1112_1314_1516, 8'h00);
        for (int n = 0; n <= 12; n++) pbs_word({8{8'(n)}}, 8'h00);
        pbs_word({8{8'h0D}}, 8'h01);
        wait_idle();

        // Data words outside a packet are dropped; next packet passes.
        pbs_word(64'h1111_2222_3333_4444, 8'h00);
        pbs_word(64'h5555_6666_7777_8888, 8'h80);
        pbs_rand_pkt(64'h0BAD_F00D_0000_0001, 3, 8'h10);
        wait_idle();

        // Downstream stall: RDY drops with three payload words queued.
        trdy_mode = 2;
        pbs_wr_cnt = 0;
        fork
            pbs_rand_pkt(64'hFEED_0000_0000_0002, 7, 8'h04);
            begin
                repeat (14) @(negedge ACLK);
                check("rdy_low_when_stalled", S_PBS_RDY, 0);
                check("tvalid_held_when_stalled", M_AXIS_TVALID, 1);
                check("words_taken_while_stalled", pbs_wr_cnt, 4);
                @(posedge ACLK); #1;
                trdy_mode = 0;
            end
        join
        wait_idle();

        // Toggling PBS ready with both directions active together.
        rdy_mode = 1;
        fork
            begin
                axis_rand_pkt(4, 8'h00, 64'h0000_0000_0000_0A01);
                axis_rand_pkt(3, 8'h07, 64'h0000_0000_0000_0A02);
                axis_rand_pkt(5, 8'($urandom_range(1, 255)), 64'h0000_0000_0000_0A03);
                axis_rand_pkt(1, 8'h01, 64'h0000_0000_0000_0A04);
            end
            begin
                pbs_rand_pkt(64'h0000_0000_0000_0B01, 5, 8'h20);
                pbs_rand_pkt(64'h0000_0000_0000_0B02, 1, 8'h02);
            end
        join
        wait_idle();
        rdy_mode = 0;
        @(posedge ACLK); #1;

        // Reset in the middle of a packet in both directions.
        trdy_mode = 2;
        pbs_word(64'hAAAA_0000_0000_0003, 8'hFF);
        pbs_word(64'h0101_0101_0101_0101, 8'h00);
        pbs_word(64'h0202_0202_0202_0202, 8'h00);
        axis_beat(64'h0303_0303_0303_0303, 8'hFF, 1'b0, 64'hBBBB_0000_0000_0004, 1'b1);
        axis_beat(64'h0404_0404_0404_0404, 8'hFF, 1'b0, 64'hBBBB_0000_0000_0004, 1'b0);
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 64'h0505_0505_0505_0505;
        S_AXIS_TSTRB  = 8'hFF;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check_reset_outputs("mid_reset");
        p2a_q.delete();
        tb_in_pkt = 1'b0;
        @(posedge ACLK); #1;
        S_AXIS_TVALID = 1'b0;
        trdy_mode = 0;
        ARESET = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("a2p_state_after_reset", DBG_A2P_STATE, 0);
        check("p2a_state_after_reset", DBG_P2A_STATE, 0);
        fork
            axis_rand_pkt(6, 8'h3F, 64'hC0DE_0000_0000_0005);
            pbs_rand_pkt(64'hC0DE_0000_0000_0006, 6, 8'h40);
        join
        wait_idle();

        repeat (5) @(posedge ACLK);
        check("a2p_queue_empty", a2p_q.size(), 0);
        check("p2a_queue_empty", p2a_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
